// File: rtl/ssd_mux_driver.sv
// Time-multiplexed common-anode seven-segment driver with per-frame snapshots and anti-ghost blanking.
// Optional SSD_LEADING_ZERO_BLANK_EN: blank segments of leading-zero digits above the top nonzero nibble.
module ssd_mux_driver #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [4*DIGITS-1:0]   x,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     en,
    output logic [6:0]            a_to_g,
    output logic [DIGITS-1:0]     an,
    output logic                  dp,
    output logic                  frame_tick
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

    logic [PW-1:0]       prescaler_q, prescaler_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] x_snap_q, x_snap_d;
    logic [DIGITS-1:0]   dp_snap_q, dp_snap_d;
    logic [DIGITS-1:0]   en_snap_q, en_snap_d;
    logic [6:0]          a_to_g_q, a_to_g_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                dp_q, dp_d;
    logic                frame_tick_q, frame_tick_d;

    logic                tick, wrap, show, zero_blank;
    logic [3:0]          cur_nib;
    logic                cur_en, cur_dp;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic [IW-1:0]       msnz;
`endif

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'b1000000;
            4'h1: hex_glyph = 7'b1111001;
            4'h2: hex_glyph = 7'b0100100;
            4'h3: hex_glyph = 7'b0110000;
            4'h4: hex_glyph = 7'b0011001;
            4'h5: hex_glyph = 7'b0010010;
            4'h6: hex_glyph = 7'b0000010;
            4'h7: hex_glyph = 7'b1111000;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0010000;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b0000011;
            4'hC: hex_glyph = 7'b1000110;
            4'hD: hex_glyph = 7'b0100001;
            4'hE: hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        tick         = (prescaler_q == PRE_MAX);
        wrap         = tick && (idx_q == IDX_MAX);
        prescaler_d  = tick ? '0 : prescaler_q + PW'(1);
        idx_d        = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end
        // Snapshot only at the frame boundary so every digit of a frame agrees.
        x_snap_d     = wrap ? x     : x_snap_q;
        dp_snap_d    = wrap ? dp_in : dp_snap_q;
        en_snap_d    = wrap ? en    : en_snap_q;
        frame_tick_d = wrap;

        cur_nib = '0;
        cur_en  = 1'b0;
        cur_dp  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib = x_snap_q[4*i +: 4];
                cur_en  = en_snap_q[i];
                cur_dp  = dp_snap_q[i];
            end
        end

        zero_blank = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        msnz = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (x_snap_q[4*i +: 4] != 4'h0) msnz = IW'(i);
        end
        zero_blank = (idx_q > msnz);
`endif

        // Anodes stay off for the first BLANK_CYCLES of every slot to avoid ghosting.
        show = (prescaler_q >= BLANK_END) && cur_en;
        an_d = '1;
        for (int i = 0; i < DIGITS; i++) begin
            an_d[i] = !(show && (idx_q == IW'(i)));
        end
        a_to_g_d = (show && !zero_blank) ? hex_glyph(cur_nib) : 7'h7F;
        dp_d     = show ? ~cur_dp : 1'b1;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            prescaler_q  <= '0;
            idx_q        <= '0;
            x_snap_q     <= '0;
            dp_snap_q    <= '0;
            en_snap_q    <= '0;
            a_to_g_q     <= 7'h7F;
            an_q         <= '1;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            prescaler_q  <= prescaler_d;
            idx_q        <= idx_d;
            x_snap_q     <= x_snap_d;
            dp_snap_q    <= dp_snap_d;
            en_snap_q    <= en_snap_d;
            a_to_g_q     <= a_to_g_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign a_to_g     = a_to_g_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ssd_mux_driver.sv
// Scoreboard bench for ssd_mux_driver: a cycle model pushes expected outputs, a negedge monitor compares.
module tb_ssd_mux_driver;
    localparam int DIGITS = 4;
    localparam int RD     = 8;
    localparam int BC     = 2;
    localparam int FRAME  = RD * DIGITS;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [15:0] x = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  en = '0;
    logic [6:0]  a_to_g;
    logic [3:0]  an;
    logic        dp;
    logic        frame_tick;

    ssd_mux_driver #(.DIGITS(DIGITS), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .clr(clr), .x(x), .dp_in(dp_in), .en(en),
        .a_to_g(a_to_g), .an(an), .dp(dp), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } exp_t;

    localparam exp_t RST_EXP = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ft: 1'b0};

    exp_t        q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          s = 0;
    logic [15:0] sx = '0;
    logic [3:0]  sdp = '0;
    logic [3:0]  sen = '0;
    logic [6:0]  glyph [16];

    task automatic check_out(input string name, input exp_t act, input exp_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t got an=%b seg=%b dp=%b ft=%b want an=%b seg=%b dp=%b ft=%b",
                      name, $time, act.an, act.seg, act.dp, act.ft, exp.an, exp.seg, exp.dp, exp.ft);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
    endtask

    task automatic run_frames(input int n);
        repeat (n * FRAME) @(posedge clk);
        #1;
    endtask

    // Reference model: s counts clock edges since reset release; outputs lag the state by one edge.
    initial forever begin
        exp_t       e;
        int         slot, pre;
        logic [3:0] nib;
        @(posedge clk);
        if (clr) begin
            q.push_back(RST_EXP);
            s = 0; sx = '0; sdp = '0; sen = '0;
        end else begin
            pre  = s % RD;
            slot = (s / RD) % DIGITS;
            nib  = sx[4*slot +: 4];
            e    = RST_EXP;
            if (pre >= BC && sen[slot]) begin
                e.an[slot] = 1'b0;
                e.seg = glyph[nib];
                if (LZ && slot != 0 && (sx >> (4*slot)) == 16'h0) e.seg = 7'h7F;
                e.dp = ~sdp[slot];
            end
            e.ft = ((s % FRAME) == FRAME - 1);
            q.push_back(e);
            if (e.ft) begin
                sx = x; sdp = dp_in; sen = en;
            end
            s++;
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            if (clr) e = RST_EXP;
            check_out("slot", {an, a_to_g, dp, frame_tick}, e);
        end
    end

    initial begin
        int cnt, bad1, bad2, lit2, guard;
        logic [3:0] first;
        glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0; x = 16'h1234; en = 4'hF; dp_in = 4'h0;
        run_frames(3);

        x = 16'hF80A;
        run_frames(2);
        x = 16'hBCDE;
        run_frames(2);
        x = 16'h3679;
        run_frames(2);

        // Change mid-frame while idx = 2; must not appear until the next frame.
        x = 16'h1111;
        run_frames(2);
        repeat (17) @(posedge clk);
        #1;
        x = 16'h2222;
        run_frames(2);
        cnt = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (frame_tick) cnt++;
        end
        check_int("frame_tick_rate", cnt, 2);
        @(posedge clk);
        #1;

        en = 4'b0101; dp_in = 4'b0100; x = 16'h9876;
        run_frames(2);
        bad1 = 0; bad2 = 0; lit2 = 0;
        repeat (FRAME) begin
            @(negedge clk);
            if (!an[1] || !an[3]) bad1++;
            if ((dp == 1'b0) != (an[2] == 1'b0)) bad2++;
            if (!an[2]) lit2++;
        end
        check_int("masked_anodes", bad1, 0);
        check_int("dp_only_digit2", bad2, 0);
        check_int("an2_lit_cycles", lit2, RD - BC);
        @(posedge clk);
        #1;

        en = 4'hF; dp_in = 4'b1000; x = 16'h0005;
        run_frames(2);
        dp_in = 4'h0; x = 16'h0000;
        run_frames(2);

        guard = 0;
        while ((s % FRAME) != 29 && guard < 2 * FRAME) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_int("reset_align", int'(guard < 2 * FRAME), 1);
        clr = 1'b1;
        #1;
        check_out("async_reset", {an, a_to_g, dp, frame_tick}, RST_EXP);
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0; x = 16'h00A1;
        first = 4'hF;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (first == 4'hF && an != 4'hF) first = an;
        end
        check_int("first_lit_after_reset", int'(first), int'(4'b1110));

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ssd_mux_driver.md
# ssd_mux_driver

Parametrised, time-multiplexed seven-segment display driver for the board's common-anode digit banks. It refreshes DIGITS digits from a packed hex word and shows the full 0–F glyph set. It adds per-digit decimal points, a per-digit enable mask, tear-free frame snapshots and anti-ghosting blanking. It sits between the switch/counter datapath and the board's anode/segment pins, and is the next generation of our single-digit static display block.

## Interface
- DIGITS, 4: number of multiplexed digits (1–8).
- REFRESH_DIV, 100000: clk cycles per digit slot (1 ms at 100 MHz); must be ≥ 2.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- x  in  4*DIGITS  hex value; digit i = x[4i+3:4i]; digit 0 is rightmost.
- dp_in  in  DIGITS  decimal point request per digit (1 = lit).
- en  in  DIGITS  digit enable mask (1 = shown).
- a_to_g  out  7  segments, active-low, bit0 = a … bit6 = g.
- an  out  DIGITS  anodes, active-low, an[i] selects digit i.
- dp  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse at the start of each frame.

## Operation
- Prescaler counts 0..REFRESH_DIV-1 and wraps. "Tick" is prescaler == REFRESH_DIV-1.
- Digit index idx advances on every tick, wrapping DIGITS-1 → 0. With DIGITS = 1, idx stays 0.
- On the tick edge that wraps idx to 0, snapshot registers capture x, dp_in and en. All digits of a frame come from one snapshot, so no mid-frame tearing occurs.
- Slot drive for idx = i:
  - Blanking region (prescaler < BLANK_CYCLES): an = all ones, a_to_g = 7'h7F, dp = 1.
  - Digit disabled (snapshot en[i] = 0): the slot is blanked for its whole duration.
  - Otherwise: an[i] = 0, all other anodes = 1, a_to_g = hex decode of snapshot nibble i, dp = ~snapshot dp_in[i].
- Hex decode, active-low: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
- Widths: prescaler is $clog2(REFRESH_DIV) bits; idx is max(1, $clog2(DIGITS)) bits.

## Timing
- Reset values: prescaler 0, idx 0, snapshots 0; an all ones, a_to_g 7'h7F, dp 1, frame_tick 0.
- First snapshot is taken on the first wrap to idx 0, i.e. DIGITS*REFRESH_DIV cycles after reset release. Before that, slots display snapshot 0, so enabled-by-default digits are dark.
- an, a_to_g and dp are registered. They reflect the prescaler/idx state of the previous cycle (1-cycle latency).
- frame_tick is registered. It is high for exactly the one cycle after the wrap-to-0 edge.
- x, dp_in and en changes mid-frame have no visible effect until the next frame boundary.
- A change that coincides with the wrap edge is captured.
- Reset asserted mid-frame immediately forces all reset values. The refresh restarts at digit 0 on release.

## Configuration
- SSD_LEADING_ZERO_BLANK_EN defined:
  - Leading-zero digits are blanked. These are digits above the most significant nonzero nibble of the snapshot, excluding digit 0.
  - A blanked digit's dp is still driven from the snapshot dp_in, and its anode is still asserted.
- SSD_LEADING_ZERO_BLANK_EN undefined: all enabled digits show their nibble, including leading zeros.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset then refresh: hold clr 3 cycles, release, x=16'h1234, en=4'hF. Outputs hold reset values until the first snapshot. From then on each digit slot i shows an[i]=0 for cycles 2–7 of its slot, with a_to_g 1111001, 0100100, 0110000, 0011001 for digits 3, 2, 1, 0 respectively.
- Hex glyphs: x=16'hF80A over one frame → digit 0 shows 0001000, digit 1 1000000, digit 2 0000000, digit 3 0001110.
- Tear-free and frame_tick: change x from 16'h1111 to 16'h2222 mid-frame at idx 2. The remainder of the frame shows 1 on every digit, and the next frame shows 2. frame_tick is high exactly 1 cycle per 32.
- Mask and dp: en=4'b0101, dp_in=4'b0100 → an[1] and an[3] are never 0, and dp=0 only while an[2]=0.
- Leading-zero blanking: x=16'h0005. With the macro defined, digits 3, 2 and 1 show 7'h7F. Without it, they show 1000000. x=16'h0000 with the macro defined → digit 0 still shows 1000000.
- Reset mid-frame: assert clr at idx 3, prescaler 5 → an=4'hF the same cycle. After release, the first lit slot is digit 0.
